lsu_bus_master: RTL

LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

---
 rtl/lsu_bus_master_if.sv | 22 ++
 rtl/lsu_bus_master.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_master_if.sv
// rtl/lsu_bus_master_if.sv - naive_bus: split read/write request-grant bus with word-wide data
interface naive_bus;
   logic        rd_req;
   logic        rd_gnt;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic        wr_req;
   logic        wr_gnt;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
      input  rd_gnt, rd_data, wr_gnt
   );

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
      output rd_gnt, rd_data, wr_gnt
   );
endinterface

// File: rtl/lsu_bus_master.sv
// rtl/lsu_bus_master.sv - load/store unit master: one sized access at a time onto naive_bus
module lsu_bus_master (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [31:0] o_rdata,
   naive_bus.master    bus
);

   typedef enum logic [1:0] {IDLE, WR, RD, RWAIT} state_e;

   state_e      state_q, state_d;
   logic [1:0]  lane_q, lane_d;
   logic [2:0]  size_q, size_d;
   logic        rd_req_q, rd_req_d;
   logic        wr_req_q, wr_req_d;
   logic [31:0] rd_addr_q, rd_addr_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic [3:0]  wr_be_q, wr_be_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   logic        illegal;
   logic [31:0] st_data;
   logic [3:0]  st_be;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   // Alignment and size-code legality of the incoming command
   always_comb begin
      illegal = 1'b0;
      case (i_funct3)
         3'b000, 3'b100: illegal = 1'b0;
         3'b001, 3'b101: illegal = i_addr[0];
         3'b010:         illegal = |i_addr[1:0];
         default:        illegal = 1'b1;
      endcase
   end

   always_comb begin
      st_data = i_wdata;
      st_be   = 4'b1111;
      case (i_funct3[1:0])
         2'b00: begin
            st_data = {4{i_wdata[7:0]}};
            st_be   = 4'b0001 << i_addr[1:0];
         end
         2'b01: begin
            st_data = {2{i_wdata[15:0]}};
            st_be   = 4'b0011 << i_addr[1:0];
         end
         default: begin
            st_data = i_wdata;
            st_be   = 4'b1111;
         end
      endcase
   end

   // Lane extraction from the word returned in RWAIT
   always_comb begin
      ld_byte = bus.rd_data[7:0];
      case (lane_q)
         2'd0: ld_byte = bus.rd_data[7:0];
         2'd1: ld_byte = bus.rd_data[15:8];
         2'd2: ld_byte = bus.rd_data[23:16];
         2'd3: ld_byte = bus.rd_data[31:24];
         default: ld_byte = bus.rd_data[7:0];
      endcase
      ld_half = lane_q[1] ? bus.rd_data[31:16] : bus.rd_data[15:0];
      case (size_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {24'h0, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {16'h0, ld_half};
         default: ld_ext = bus.rd_data;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      lane_d    = lane_q;
      size_d    = size_q;
      rd_req_d  = rd_req_q;
      wr_req_d  = wr_req_q;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_be_d   = wr_be_q;
      rdata_d   = rdata_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_req) begin
               if (illegal) begin
                  err_d = 1'b1;
               end else begin
                  lane_d = i_addr[1:0];
                  size_d = i_funct3;
                  if (i_we) begin
                     state_d   = WR;
                     wr_req_d  = 1'b1;
                     wr_addr_d = {i_addr[31:2], 2'b00};
                     wr_data_d = st_data;
                     wr_be_d   = st_be;
                  end else begin
                     state_d   = RD;
                     rd_req_d  = 1'b1;
                     rd_addr_d = {i_addr[31:2], 2'b00};
                  end
               end
            end
         end
         WR: begin
            if (bus.wr_gnt) begin
               state_d  = IDLE;
               wr_req_d = 1'b0;
               wr_be_d  = 4'b0000;
               done_d   = 1'b1;
            end
         end
         RD: begin
            if (bus.rd_gnt) begin
               state_d  = RWAIT;
               rd_req_d = 1'b0;
            end
         end
         RWAIT: begin
            state_d = IDLE;
            rdata_d = ld_ext;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         lane_q    <= 2'b00;
         size_q    <= 3'b000;
         rd_req_q  <= 1'b0;
         wr_req_q  <= 1'b0;
         rd_addr_q <= 32'h0;
         wr_addr_q <= 32'h0;
         wr_data_q <= 32'h0;
         wr_be_q   <= 4'b0000;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= 32'h0;
      end else begin
         state_q   <= state_d;
         lane_q    <= lane_d;
         size_q    <= size_d;
         rd_req_q  <= rd_req_d;
         wr_req_q  <= wr_req_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_be_q   <= wr_be_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign o_busy      = (state_q != IDLE);
   assign o_done      = done_q;
   assign o_err       = err_q;
   assign o_rdata     = rdata_q;
   assign bus.rd_req  = rd_req_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.wr_req  = wr_req_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.wr_be   = wr_be_q;

endmodule
